mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port memory, with a busy timeout.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise data always wins.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [7:0]  TIMEOUT_CNT  = 8'(TIMEOUT);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  state_t     state;
  logic [7:0] busy_cnt;
  logic       i_pend;
  logic       d_pend;
  logic       grant_d;

  // A request whose valid is high this cycle is the one just served, not a new one.
  assign i_pend = i_req & ~i_valid;
  assign d_pend = d_req & ~d_valid;
  assign stall  = i_pend | d_pend;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  assign grant_d = d_pend & (~i_pend | ~last_d);

  // Only contested grants move the pointer, so each tie alternates regardless of solo traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (state == IDLE && i_pend && d_pend) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_pend;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy_cnt    <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_func3   <= 3'b000;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      i_rdata     <= 32'd0;
      i_valid     <= 1'b0;
      d_rdata     <= 32'd0;
      d_valid     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            busy_cnt  <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_func3 <= d_func3;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (i_pend) begin
            // Fetches are always full-word reads (LW encoding).
            state     <= BUSY_I;
            busy_cnt  <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_func3 <= 3'b010;
            mem_addr  <= i_addr;
            mem_wdata <= 32'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          // mem_ready wins over a timeout landing on the same cycle.
          if (mem_ready || busy_cnt == TIMEOUT_CNT) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_func3 <= 3'b000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if (!mem_ready) begin
              timeout_err <= 1'b1;
            end
            if (state == BUSY_I) begin
              i_valid <= 1'b1;
              i_rdata <= mem_ready ? mem_rdata : TIMEOUT_DATA;
            end else begin
              d_valid <= 1'b1;
              if (!mem_ready) begin
                d_rdata <= TIMEOUT_DATA;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
